// File: rtl/demux3_router_if.sv
// Bundle of the producer stream, the three consumer streams and the per-channel
// accept counters that connect demux3_router to its environment.
interface demux3_router_if #(
  parameter int W = 3
);
  // Handshake rules for every stream in this bundle (m, u, v, w):
  // a word transfers on a rising edge where valid && ready are both 1.
  // valid never waits for ready. The router raises m_ready from its select
  // and stored fill level only, and X_valid/X are driven from registers only.
  logic         s1;
  logic         s0;
  logic [W-1:0] m;
  logic         m_valid;
  logic         m_ready;

  logic [W-1:0] u;
  logic [W-1:0] v;
  logic [W-1:0] w;
  logic         u_valid;
  logic         v_valid;
  logic         w_valid;
  logic         u_ready;
  logic         v_ready;
  logic         w_ready;

  logic [7:0]   cnt_u;
  logic [7:0]   cnt_v;
  logic [7:0]   cnt_w;

  modport slave (
    input  s1, s0, m, m_valid, u_ready, v_ready, w_ready,
    output m_ready, u, v, w, u_valid, v_valid, w_valid, cnt_u, cnt_v, cnt_w
  );

  modport master (
    output s1, s0, m, m_valid, u_ready, v_ready, w_ready,
    input  m_ready, u, v, w, u_valid, v_valid, w_valid, cnt_u, cnt_v, cnt_w
  );
endinterface

// File: rtl/demux3_router.sv
// Registered 1-to-3 stream distributor: each input word goes to channel u, v or w
// by {s1,s0} and waits in that channel's own FIFO until its consumer takes it.
module demux3_router #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  demux3_router_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] CH_U = 2'd0;
  localparam logic [1:0] CH_V = 2'd1;
  localparam logic [1:0] CH_W = 2'd2;

  logic [1:0]          tgt;
  logic                m_ready_int;
  logic [2:0]          full;
  logic [2:0]          nonempty;
  logic [2:0]          push;
  logic [2:0]          pop;
  logic [2:0]          cons_ready;
  logic [2:0][W-1:0]   head;
  logic [2:0][7:0]     acc;

  // Select 11 aliases to u, matching the companion 3:1 mux table.
  always_comb begin
    tgt = CH_U;
    case ({bus.s1, bus.s0})
      2'b01:   tgt = CH_V;
      2'b10:   tgt = CH_W;
      default: tgt = CH_U;
    endcase
  end

  // No bypass: a pop in this cycle does not free the slot for a push.
  assign m_ready_int = !full[tgt];
  assign cons_ready  = {bus.w_ready, bus.v_ready, bus.u_ready};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    acc_cnt;

    assign full[c]     = (count == CW'(DEPTH));
    assign nonempty[c] = (count != '0);
    assign push[c]     = bus.m_valid && m_ready_int && (tgt == 2'(c));
    assign pop[c]      = nonempty[c] && cons_ready[c];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        acc_cnt <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push[c]) begin
          mem[wr_ptr] <= bus.m;
          wr_ptr      <= wr_ptr + 1'b1;
          acc_cnt     <= acc_cnt + 8'd1;
        end
        if (pop[c]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push[c] && !pop[c]) begin
          count <= count + 1'b1;
        end else if (pop[c] && !push[c]) begin
          count <= count - 1'b1;
        end
      end
    end

    // Empty FIFOs present zero rather than a stale entry.
    assign head[c] = nonempty[c] ? mem[rd_ptr] : '0;
    assign acc[c]  = acc_cnt;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CW'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      full[c] |-> !push[c]);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
      !nonempty[c] |-> !pop[c]);
  end

  assign bus.m_ready = m_ready_int;
  assign bus.u       = head[0];
  assign bus.v       = head[1];
  assign bus.w       = head[2];
  assign bus.u_valid = nonempty[0];
  assign bus.v_valid = nonempty[1];
  assign bus.w_valid = nonempty[2];
  assign bus.cnt_u   = acc[0];
  assign bus.cnt_v   = acc[1];
  assign bus.cnt_w   = acc[2];

  a_one_hot_push: assert property (@(posedge clk) disable iff (rst)
    $onehot0(push));
endmodule
